// File: rtl/video_source_scheduler.sv
// video_source_scheduler
//
// Frame-synchronous arbiter between two 24-bit ready/valid pixel sources
// (source 0: pattern generator, source 1: processed-image stream) and a
// single DVI video sink. The raster position of the next pixel is tracked,
// and the granted source only changes at a frame boundary, so no frame is
// ever torn. Page toggles on every completed frame. The pattern generator
// uses it to alternate colour sets.
//
// Optional feature macro: UNDERFLOW_FILL_EN
//   defined   - while ACTIVE, a granted source with Valid low is replaced by
//               FillColor pixels that advance the raster, and UnderflowCount
//               counts them (saturating).
//   undefined - no fill logic. The sink stalls on underflow, and
//               UnderflowCount is tied to 0.
//
// Ports:
//   Clock, Reset           rising-edge clock, synchronous active-low reset
//   Enable                 run request; 0 parks the block at the next frame end
//   Select                 requested source, sampled only at frame boundaries
//   Src0Video/Valid/Ready  source 0 stream
//   Src1Video/Valid/Ready  source 1 stream
//   Video/VideoValid/VideoReady  sink stream
//   ActiveSource           currently granted source
//   PixelX, PixelY         raster position of the next pixel to transfer
//   Page                   frame parity
//   FrameDone              one-cycle pulse after the last pixel of a frame
//   UnderflowCount         saturating count of fill pixels emitted
//   DebugState             current FSM state (0 IDLE, 1 ACTIVE, 2 SWITCH)
//
// Handshake: a beat moves on any cycle where valid and ready are both high.
// A producer holds its data stable while valid is high and ready is low.
// Ready never depends on the same interface's valid. While ACTIVE, the
// granted source's Ready is the sink's VideoReady, passed through
// combinationally with zero latency.

module video_source_scheduler #(
    parameter int          Width     = 800,
    parameter int          Height    = 600,
    parameter int          XW        = 10,
    parameter int          YW        = 10,
    parameter logic [23:0] FillColor = 24'h000000
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Enable,
    input  logic          Select,
    input  logic [23:0]   Src0Video,
    input  logic          Src0Valid,
    output logic          Src0Ready,
    input  logic [23:0]   Src1Video,
    input  logic          Src1Valid,
    output logic          Src1Ready,
    output logic [23:0]   Video,
    output logic          VideoValid,
    input  logic          VideoReady,
    output logic          ActiveSource,
    output logic [XW-1:0] PixelX,
    output logic [YW-1:0] PixelY,
    output logic          Page,
    output logic          FrameDone,
    output logic [15:0]   UnderflowCount,
    output logic [1:0]    DebugState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t state;

    logic        grantValid;
    logic [23:0] grantVideo;
    logic        transfer;
    logic        lastX;
    logic        lastY;
    logic        lastPixel;
`ifdef UNDERFLOW_FILL_EN
    logic        fillPixel;
`endif

    assign DebugState = state;

    assign grantValid = ActiveSource ? Src1Valid : Src0Valid;
    assign grantVideo = ActiveSource ? Src1Video : Src0Video;

    // Sink-side mux. Outside ACTIVE, everything is idle and Video is forced to 0.
    always_comb begin
        Video      = 24'h000000;
        VideoValid = 1'b0;
        Src0Ready  = 1'b0;
        Src1Ready  = 1'b0;
`ifdef UNDERFLOW_FILL_EN
        fillPixel  = 1'b0;
`endif
        if (state == ACTIVE) begin
            Video      = grantVideo;
            VideoValid = grantValid;
            if (ActiveSource) begin
                Src1Ready = VideoReady;
            end else begin
                Src0Ready = VideoReady;
            end
`ifdef UNDERFLOW_FILL_EN
            // Substitute a fill pixel so the sink never sees a gap.
            if (!grantValid) begin
                Video      = FillColor;
                VideoValid = 1'b1;
                fillPixel  = 1'b1;
            end
`endif
        end
    end

    assign transfer  = VideoValid && VideoReady;
    assign lastX     = (PixelX == XW'(Width - 1));
    assign lastY     = (PixelY == YW'(Height - 1));
    assign lastPixel = transfer && lastX && lastY;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state          <= IDLE;
            PixelX         <= '0;
            PixelY         <= '0;
            Page           <= 1'b0;
            ActiveSource   <= 1'b0;
            FrameDone      <= 1'b0;
`ifdef UNDERFLOW_FILL_EN
            UnderflowCount <= 16'h0000;
`endif
        end else begin
            FrameDone <= lastPixel;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        ActiveSource <= Select;
                        state        <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (transfer) begin
                        if (lastX) begin
                            PixelX <= '0;
                            if (lastY) begin
                                // Frame boundary. This is the only point where
                                // Enable and Select are acted on.
                                PixelY <= '0;
                                Page   <= ~Page;
                                if (!Enable) begin
                                    state <= IDLE;
                                end else if (Select != ActiveSource) begin
                                    state <= SWITCH;
                                end
                            end else begin
                                PixelY <= PixelY + 1'b1;
                            end
                        end else begin
                            PixelX <= PixelX + 1'b1;
                        end
`ifdef UNDERFLOW_FILL_EN
                        if (fillPixel && (UnderflowCount != 16'hFFFF)) begin
                            UnderflowCount <= UnderflowCount + 16'h0001;
                        end
`endif
                    end
                end
                SWITCH: begin
                    // A single bubble cycle. The grant flips as the next frame
                    // starts.
                    ActiveSource <= ~ActiveSource;
                    state        <= ACTIVE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UNDERFLOW_FILL_EN
    assign UnderflowCount = 16'h0000;
`endif

endmodule

// File: tb/tb_video_source_scheduler.sv
// Testbench for video_source_scheduler on a 4x2 raster.
// Each source emits a distinct pixel sequence (base ^ beat index). Expected
// sink pixels are queued when a frame is planned, and they are popped on
// every observed sink transfer.

module tb_video_source_scheduler;

    localparam int          W    = 4;
    localparam int          H    = 2;
    localparam logic [23:0] FILL = 24'hf0f0f0;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ACTIVE = 2'd1;
    localparam logic [1:0]  S_SWITCH = 2'd2;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        Select;
    logic [23:0] Src0Video;
    logic        Src0Valid;
    logic        Src0Ready;
    logic [23:0] Src1Video;
    logic        Src1Valid;
    logic        Src1Ready;
    logic [23:0] Video;
    logic        VideoValid;
    logic        VideoReady;
    logic        ActiveSource;
    logic [9:0]  PixelX;
    logic [9:0]  PixelY;
    logic        Page;
    logic        FrameDone;
    logic [15:0] UnderflowCount;
    logic [1:0]  DebugState;

    video_source_scheduler #(
        .Width(W), .Height(H), .XW(10), .YW(10), .FillColor(FILL)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Select(Select),
        .Src0Video(Src0Video), .Src0Valid(Src0Valid), .Src0Ready(Src0Ready),
        .Src1Video(Src1Video), .Src1Valid(Src1Valid), .Src1Ready(Src1Ready),
        .Video(Video), .VideoValid(VideoValid), .VideoReady(VideoReady),
        .ActiveSource(ActiveSource), .PixelX(PixelX), .PixelY(PixelY),
        .Page(Page), .FrameDone(FrameDone), .UnderflowCount(UnderflowCount),
        .DebugState(DebugState)
    );

    // Clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Scoreboard state
    logic [23:0] exp_q[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int xfer_count = 0;
    int idx0 = 0, idx1 = 0;     // beats actually consumed from each source
    int next0 = 0, next1 = 0;   // beats already planned into exp_q
    logic hs0, hs1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_src(input int src, input int n);
        for (int i = 0; i < n; i++) begin
            if (src == 1) begin
                exp_q.push_back(24'h1abc9c ^ 24'(next1));
                next1++;
            end else begin
                exp_q.push_back(24'h8e44ad ^ 24'(next0));
                next0++;
            end
        end
    endtask

    // One clock cycle: watch the sink mid-cycle, then let the sources advance.
    task automatic tick();
        logic [23:0] exp_pix;
        @(negedge Clock);
        hs0 = Src0Valid && Src0Ready;
        hs1 = Src1Valid && Src1Ready;
        if (VideoValid && VideoReady) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_xfer: observed %0h expected none", Video);
            end
            if (exp_q.size() != 0) begin
                exp_pix = exp_q.pop_front();
                check("pixel", 32'(Video), 32'(exp_pix));
            end
            xfer_count++;
        end
        @(posedge Clock);
        #1;
        if (hs0) idx0++;
        if (hs1) idx1++;
        Src0Video = 24'h8e44ad ^ 24'(idx0);
        Src1Video = 24'h1abc9c ^ 24'(idx1);
        #1;
    endtask

    task automatic wait_xfers(input int target, output int ticks);
        ticks = 0;
        while (xfer_count < target && ticks < 40) begin
            tick();
            ticks++;
        end
        check("wait_xfers", 32'(xfer_count), 32'(target));
    endtask

    task automatic check_parked(input string tag);
        check({tag, "_state"}, 32'(DebugState), 32'(S_IDLE));
        check({tag, "_valid"}, 32'(VideoValid), 32'd0);
        check({tag, "_rdy0"},  32'(Src0Ready),  32'd0);
        check({tag, "_rdy1"},  32'(Src1Ready),  32'd0);
        check({tag, "_video"}, 32'(Video),      32'd0);
        check({tag, "_x"},     32'(PixelX),     32'd0);
        check({tag, "_y"},     32'(PixelY),     32'd0);
    endtask

    initial begin
        int t;
        int base;
        Reset = 1'b0; Enable = 1'b0; Select = 1'b0;
        Src0Valid = 1'b0; Src1Valid = 1'b0; VideoReady = 1'b0;
        Src0Video = 24'h8e44ad; Src1Video = 24'h1abc9c;

        // Reset state
        tick(); tick();
        check_parked("reset");
        check("reset_page", 32'(Page), 32'd0);
        check("reset_src",  32'(ActiveSource), 32'd0);
        check("reset_fd",   32'(FrameDone), 32'd0);
        check("reset_ufc",  32'(UnderflowCount), 32'd0);

        // Frame 1 from source 0, with frame 2 queued back to back
        push_src(0, 8);
        push_src(0, 8);
        Reset = 1'b1; Enable = 1'b1; Select = 1'b0;
        Src0Valid = 1'b1; Src1Valid = 1'b1; VideoReady = 1'b1;
        wait_xfers(8, t);
        check("f1_cycles", 32'(t), 32'd9);
        check("f1_fd",     32'(FrameDone), 32'd1);
        check("f1_page",   32'(Page), 32'd1);
        check("f1_x",      32'(PixelX), 32'd0);
        check("f1_y",      32'(PixelY), 32'd0);
        check("f1_state",  32'(DebugState), 32'(S_ACTIVE));
        tick();
        check("f2_nobubble", 32'(xfer_count), 32'd9);
        check("f2_fd_pulse", 32'(FrameDone), 32'd0);

        // Select raised at pixel 3 only takes effect after the frame ends
        wait_xfers(11, t);
        check("sel_x", 32'(PixelX), 32'd3);
        Select = 1'b1;
        push_src(1, 8);
        wait_xfers(16, t);
        check("sw_state", 32'(DebugState), 32'(S_SWITCH));
        check("sw_src",   32'(ActiveSource), 32'd0);
        check("sw_valid", 32'(VideoValid), 32'd0);
        check("sw_rdy0",  32'(Src0Ready), 32'd0);
        check("sw_rdy1",  32'(Src1Ready), 32'd0);
        check("sw_fd",    32'(FrameDone), 32'd1);
        check("sw_page",  32'(Page), 32'd0);
        tick();
        check("sw_bubble", 32'(xfer_count), 32'd16);
        check("f3_src",    32'(ActiveSource), 32'd1);
        check("f3_state",  32'(DebugState), 32'(S_ACTIVE));
        check("f3_rdy0",   32'(Src0Ready), 32'd0);
        check("f3_rdy1",   32'(Src1Ready), 32'd1);

        // Sink stall at PixelX == 2
        wait_xfers(18, t);
        VideoReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_x",     32'(PixelX), 32'd2);
            check("stall_rdy1",  32'(Src1Ready), 32'd0);
            check("stall_video", 32'(Video), 32'(exp_q[0]));
        end
        check("stall_count", 32'(xfer_count), 32'd18);
        VideoReady = 1'b1;

        // Enable dropped mid-frame: the frame finishes, then the block parks
        Enable = 1'b0;
        wait_xfers(24, t);
        check_parked("park");
        check("park_page", 32'(Page), 32'd1);
        tick(); tick();
        check("park_hold", 32'(DebugState), 32'(S_IDLE));

        // Re-enable on source 0, then reset at pixel 5
        push_src(0, 8);
        Enable = 1'b1; Select = 1'b0;
        wait_xfers(29, t);
        check("re_page", 32'(Page), 32'd1);
        check("re_x",    32'(PixelX), 32'd1);
        check("re_y",    32'(PixelY), 32'd1);
        check("re_src",  32'(ActiveSource), 32'd0);
        Reset = 1'b0;
        tick();
        check_parked("rst5");
        check("rst5_page", 32'(Page), 32'd0);
        check("rst5_src",  32'(ActiveSource), 32'd0);
        exp_q.delete();
        next0 = idx0;
        next1 = idx1;

        // Source 0 drops Valid for three cycles at PixelX == 2
        base = xfer_count;
        push_src(0, 2);
`ifdef UNDERFLOW_FILL_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(FILL);
        push_src(0, 3);
`else
        push_src(0, 6);
`endif
        Reset = 1'b1;
        wait_xfers(base + 2, t);
        check("uf_x0", 32'(PixelX), 32'd2);
        Src0Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifndef UNDERFLOW_FILL_EN
            check("uf_valid", 32'(VideoValid), 32'd0);
`endif
        end
`ifdef UNDERFLOW_FILL_EN
        check("uf_x", 32'(PixelX), 32'd5);
        check("uf_count", 32'(UnderflowCount), 32'd3);
`else
        check("uf_x", 32'(PixelX), 32'd2);
        check("uf_count", 32'(UnderflowCount), 32'd0);
`endif
        Src0Valid = 1'b1;
        Enable = 1'b0;
        wait_xfers(base + 8, t);
        check("uf_fd",   32'(FrameDone), 32'd1);
        check("uf_page", 32'(Page), 32'd1);
        check_parked("end");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_source_scheduler.md
Name: video_source_scheduler

Overview:
- Frame-synchronous arbiter between two 24-bit ready/valid pixel sources and the single DVI video sink.
  - Source 0: pattern generator.
  - Source 1: processed-image stream.
- Tracks raster position and switches sources only at frame boundaries, so no frame is ever torn.
- Provides a frame-parity page bit that the pattern generator uses to alternate colour sets per frame.

Parameters:
- Width, 800, active pixels per line.
- Height, 600, active lines per frame.
- XW, 10, width of the PixelX counter.
- YW, 10, width of the PixelY counter.
- FillColor, 24'h000000, pixel emitted on underflow (optional feature only).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset).
- Enable  in  1  run request; 0 parks the block at the next frame boundary.
- Select  in  1  requested source (0 or 1); sampled only at frame boundaries.
- Src0Video  in  24  source 0 pixel.
- Src0Valid  in  1  source 0 valid.
- Src0Ready  out  1  source 0 ready.
- Src1Video  in  24  source 1 pixel.
- Src1Valid  in  1  source 1 valid.
- Src1Ready  out  1  source 1 ready.
- Video  out  24  pixel to sink.
- VideoValid  out  1  pixel valid to sink.
- VideoReady  in  1  sink ready.
- ActiveSource  out  1  currently granted source.
- PixelX  out  XW  column of the next pixel to transfer.
- PixelY  out  YW  line of the next pixel to transfer.
- Page  out  1  frame parity; toggles on each completed frame.
- FrameDone  out  1  one-cycle pulse on the cycle after the last pixel of a frame transfers.
- UnderflowCount  out  16  saturating count of fill pixels emitted.

Behaviour:
- Transfer: a sink transfer occurs on any cycle with VideoValid && VideoReady.
- Reset (Reset==0 at a rising edge), regardless of state or mid-frame:
  - State = IDLE.
  - PixelX = PixelY = 0.
  - Page = 0, ActiveSource = 0, FrameDone = 0, UnderflowCount = 0.
  - All Ready/Valid outputs deasserted; Video = 0.
- FSM states: IDLE, ACTIVE, SWITCH.
- IDLE:
  - VideoValid = 0, Src0Ready = 0, Src1Ready = 0, Video = 0.
  - If Enable == 1: ActiveSource <= Select, go to ACTIVE.
- ACTIVE:
  - Zero-latency combinational pass-through of the granted source: Video = SrcNVideo, VideoValid = SrcNValid, SrcNReady = VideoReady.
  - The non-granted source's Ready = 0.
  - On each transfer, PixelX increments. At PixelX == Width-1, PixelX wraps to 0 and PixelY increments.
- Last pixel: a transfer at (Width-1, Height-1).
  - PixelY wraps to 0 and Page toggles.
  - FrameDone is high on the following cycle.
  - Next state, evaluated on the last-pixel cycle in priority order:
    1. Enable == 0 → IDLE.
    2. Select != ActiveSource → SWITCH.
    3. Otherwise stay in ACTIVE. Back-to-back frames incur no bubble.
- SWITCH:
  - Exactly one cycle; no transfers (all Valid/Ready low).
  - ActiveSource <= ~ActiveSource, then go to ACTIVE.
- Select or Enable changes mid-frame have no effect until the last-pixel cycle.
- Stall: if VideoReady == 0, position and source data hold. The upstream source is responsible for holding its data per the ready/valid rules.
- The source's Valid may drop mid-frame; without the optional feature the sink simply sees VideoValid = 0.
- Counter width: PixelX/PixelY hold 0..Width-1 and 0..Height-1 only; they never reach Width or Height.

Optional Feature:
- Macro: UNDERFLOW_FILL_EN.
- Defined:
  - In ACTIVE, when the granted source's Valid == 0, VideoValid = 1 and Video = FillColor.
  - A fill pixel that transfers advances position like a real pixel and increments UnderflowCount, saturating at 16'hFFFF.
  - The granted source's Ready still follows VideoReady.
- Undefined:
  - No fill logic is synthesized.
  - UnderflowCount is tied to 0.
  - The sink stalls on source underflow.

Test Plan:
- Width=4, Height=2. Reset low 2 cycles, then Enable=1, Select=0, Src0Valid=1 streaming 24'h8e44ad, VideoReady=1 → Video 8e44ad for 8 transfers; FrameDone pulses at cycle 9; Page=1; PixelX/PixelY back to 0,0.
- Same setup, Select driven to 1 at pixel 3 → switch deferred: pixels 3–7 still from Src0; one SWITCH bubble cycle; next frame carries Src1Video 24'h1abc9c; ActiveSource=1.
- VideoReady=0 for 5 cycles at PixelX=2 → PixelX holds at 2; Video holds the same pixel; Src0Ready=0; resumes with no pixel loss.
- Enable dropped mid-frame → frame completes all 8 transfers, then IDLE with VideoValid=0; re-assert Enable → restarts at (0,0) with Page preserved.
- Reset asserted at pixel 5 → next cycle PixelX=0, PixelY=0, Page=0, IDLE, all Ready/Valid low.
- With UNDERFLOW_FILL_EN defined: Src0Valid=0 for 3 cycles with VideoReady=1 → 3 FillColor pixels transferred; PixelX advances 3; UnderflowCount=3.
